// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and its companion receiver:
//   - tx_state_e   : transmitter frame FSM states
//   - PARITY_*     : encodings for the PARITY_MODE parameter
//   - calc_div_cnt : clock divider shared by both ends so that the
//                    transmitter bit period equals the receiver's
//                    DIV_CNT*OVERSAMPLE clocks
// ---------------------------------------------------------------------------
package uart_pkg;

    // Transmitter frame states, in the order they occur on the line
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Clocks per oversample tick; integer division, so the achieved baud
    // rate may sit slightly above the requested one
    function automatic int calc_div_cnt(input int clk_freq,
                                        input int baud_rate,
                                        input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter for the UART transmitter.
// Ports:
//   clk_i     : system clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   clear_i   : hold the counter at zero (used while the line is idle)
//   bit_end_o : high on the last clock (count BIT_CLKS-1) of each bit period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int BIT_CLKS = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = (cnt_q == LAST_CNT);

    // Wrapping to zero at the end of every bit means each new state or bit
    // starts from a fresh count, so the bit period never drifts
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. A one-entry holding register lets the producer queue the
// next byte during a frame so frames can run back to back with no idle gap.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset, aborts any frame
//   tx_data  : byte to send
//   tx_valid : tx_data valid
//   tx_ready : holding register empty; byte taken when tx_valid && tx_ready
//   TxD      : registered serial line, idle high
//   tx_busy  : high while any frame bit is on the line
//   tx_done  : one-clock pulse on the final clock of the last stop bit
// ---------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIV_CNT  = calc_div_cnt(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int BIT_CLKS = DIV_CNT * OVERSAMPLE;
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    if (DIV_CNT < 1) begin : g_bad_div
        $error("uart_transmitter: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (PARITY_MODE > 2 || PARITY_MODE < 0) begin : g_bad_parity
        $error("uart_transmitter: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_full_q, hold_full_d;
    logic       parity_q, parity_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       txd_q, txd_d;
    logic       bit_end;
    logic       load;
    logic       accept;

    // The timer is held at zero while idle, so the first bit after a load
    // gets a full BIT_CLKS period
    uart_bit_timer #(
        .BIT_CLKS (BIT_CLKS)
    ) u_bit_timer (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .clear_i   (state_q == TX_IDLE),
        .bit_end_o (bit_end)
    );

    assign tx_ready = !hold_full_q;
    assign tx_busy  = (state_q != TX_IDLE);
    assign tx_done  = (state_q == TX_STOP) && bit_end && (bit_cnt_q == LAST_STOP);
    assign TxD      = txd_q;
    assign accept   = tx_valid && !hold_full_q;

    // Frame sequencing, holding register and next line value. The line
    // value is derived from the next state so TxD is registered yet still
    // changes on the same edge as the state it belongs to.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        load        = 1'b0;
        txd_d       = 1'b1;

        case (state_q)
            TX_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_cnt_d = '0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != PARITY_NONE) ? TX_PARITY : TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_d   = TX_STOP;
                    bit_cnt_d = '0;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_STOP) begin
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // Parity comes from the byte as loaded, not the shifting copy
        if (load) begin
            shift_d     = hold_data_q;
            parity_d    = (PARITY_MODE == PARITY_ODD) ? ~^hold_data_q : ^hold_data_q;
            state_d     = TX_START;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
        end

        // A same-cycle accept overrides the clear from a load, so the new
        // byte stays queued behind the one just consumed
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end

        case (state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shift_d[0];
            TX_PARITY: txd_d = parity_d;
            default:   txd_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces an idle, empty transmitter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= TX_IDLE;
            shift_q     <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            txd_q       <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
// Directed bench for uart_transmitter at 1.6 MHz / 10 kbaud / x16, giving a
// 160-clock bit. Four instances cover no parity, even parity, odd parity
// and two stop bits; they share tx_data and reset, with separate tx_valid.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD_RATE  = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT        = 160;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic [3:0] validV;
    logic [3:0] readyV;
    logic [3:0] txdV;
    logic [3:0] busyV;
    logic [3:0] doneV;

    int checks = 0;
    int errors = 0;

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
                       .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(validV[0]),
        .tx_ready(readyV[0]), .TxD(txdV[0]), .tx_busy(busyV[0]), .tx_done(doneV[0]));

    uart_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
                       .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(validV[1]),
        .tx_ready(readyV[1]), .TxD(txdV[1]), .tx_busy(busyV[1]), .tx_done(doneV[1]));

    uart_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
                       .PARITY_MODE(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(validV[2]),
        .tx_ready(readyV[2]), .TxD(txdV[2]), .tx_busy(busyV[2]), .tx_done(doneV[2]));

    uart_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
                       .PARITY_MODE(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(validV[3]),
        .tx_ready(readyV[3]), .TxD(txdV[3]), .tx_busy(busyV[3]), .tx_done(doneV[3]));

    // Advance one clock and settle just after the rising edge
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counted, and reported on mismatch
    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Present a byte to instance k for exactly one edge
    task automatic applyStimulus(input int k, input logic [7:0] b);
        tx_data   = b;
        validV[k] = 1'b1;
        stepClk();
        validV[k] = 1'b0;
    endtask

    task automatic checkIdle(input int k, input string tag);
        checkOutput({tag, "_busy"}, busyV[k], 1'b0);
        checkOutput({tag, "_txd"},  txdV[k],  1'b1);
        checkOutput({tag, "_done"}, doneV[k], 1'b0);
    endtask

    // Walk a frame from frame clock startClk (1 = first start-bit clock) to
    // its final clock, checking the line at the first, middle and last clock
    // of every bit, tx_busy at both ends and the tx_done pulse position.
    // Returns positioned on the final clock of the frame.
    task automatic checkFrame(input int k, input logic [7:0] b, input int par,
                              input int stops, input int startClk);
        logic bits [12];
        int   nBits;
        int   total;
        int   bi;
        int   off;
        for (int i = 0; i < 12; i++) bits[i] = 1'b1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        nBits = 9;
        if (par == 1) begin
            bits[9] = ^b;
            nBits   = 10;
        end else if (par == 2) begin
            bits[9] = ~^b;
            nBits   = 10;
        end
        nBits = nBits + stops;
        total = nBits * BIT;
        for (int c = startClk; c <= total; c++) begin
            bi  = (c - 1) / BIT;
            off = (c - 1) % BIT;
            if (off == 0 || off == BIT/2 || off == BIT-1)
                checkOutput($sformatf("u%0d_%02h_bit%0d_off%0d", k, b, bi, off), txdV[k], bits[bi]);
            if (c == startClk || c == total)
                checkOutput($sformatf("u%0d_%02h_busy_clk%0d", k, b, c), busyV[k], 1'b1);
            if (c == total - BIT || c == total - 1)
                checkOutput($sformatf("u%0d_%02h_done_clk%0d", k, b, c), doneV[k], 1'b0);
            if (c == total)
                checkOutput($sformatf("u%0d_%02h_done_clk%0d", k, b, c), doneV[k], 1'b1);
            if (c < total) stepClk();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        tx_data = 8'h00;
        validV  = 4'b0000;
        $display("[TB] start");

        // Reset state of every instance
        repeat (3) stepClk();
        for (int k = 0; k < 4; k++) begin
            checkIdle(k, $sformatf("rst_u%0d", k));
            checkOutput($sformatf("rst_u%0d_ready", k), readyV[k], 1'b1);
        end
        reset_n = 1'b1;
        stepClk();

        // 1: single 0xA5, start bit one clock after accept, 1600-clock frame
        $display("[TB] single byte 0xA5");
        applyStimulus(0, 8'hA5);
        checkOutput("t1_ready_after_accept", readyV[0], 1'b0);
        checkOutput("t1_txd_before_start",   txdV[0],   1'b1);
        checkOutput("t1_busy_before_start",  busyV[0],  1'b0);
        stepClk();
        checkFrame(0, 8'hA5, 0, 1, 1);
        stepClk();
        checkIdle(0, "t1_after");

        // 2: back-to-back 0x00, 0xFF with tx_valid held, third byte stalls
        $display("[TB] back to back");
        tx_data   = 8'h00;
        validV[0] = 1'b1;
        stepClk();
        checkOutput("t2_ready_full", readyV[0], 1'b0);
        tx_data = 8'hFF;
        stepClk();
        checkOutput("t2_start0", txdV[0], 1'b0);
        checkOutput("t2_ready_freed", readyV[0], 1'b1);
        stepClk();
        checkOutput("t2_ready_refull", readyV[0], 1'b0);
        tx_data = 8'h5A;
        checkFrame(0, 8'h00, 0, 1, 2);
        checkOutput("t2_third_stalled", readyV[0], 1'b0);
        stepClk();
        checkOutput("t2_start1_no_gap", txdV[0], 1'b0);
        checkOutput("t2_busy_no_gap", busyV[0], 1'b1);
        checkOutput("t2_ready_at_start1", readyV[0], 1'b1);
        stepClk();
        validV[0] = 1'b0;
        checkOutput("t2_third_taken", readyV[0], 1'b0);
        checkFrame(0, 8'hFF, 0, 1, 2);
        stepClk();
        checkFrame(0, 8'h5A, 0, 1, 1);
        stepClk();
        checkIdle(0, "t2_after");

        // 3: 0x07 with even parity (bit 1) and odd parity (bit 0)
        $display("[TB] parity");
        applyStimulus(1, 8'h07);
        stepClk();
        checkFrame(1, 8'h07, 1, 1, 1);
        stepClk();
        checkIdle(1, "t3_even_after");
        applyStimulus(2, 8'h07);
        stepClk();
        checkFrame(2, 8'h07, 2, 1, 1);
        stepClk();
        checkIdle(2, "t3_odd_after");

        // 4: two stop bits, held byte follows immediately
        $display("[TB] two stop bits");
        applyStimulus(3, 8'h3C);
        stepClk();
        applyStimulus(3, 8'hC3);
        checkFrame(3, 8'h3C, 0, 2, 2);
        stepClk();
        checkFrame(3, 8'hC3, 0, 2, 1);
        stepClk();
        checkIdle(3, "t4_after");

        // 5: asynchronous reset in data bit 3 of 0x55, with a byte queued
        $display("[TB] reset mid frame");
        applyStimulus(0, 8'h55);
        stepClk();
        applyStimulus(0, 8'h99);
        repeat (698) stepClk();
        checkOutput("t5_pre_txd_bit3", txdV[0], 1'b0);
        checkOutput("t5_pre_busy", busyV[0], 1'b1);
        checkOutput("t5_pre_ready", readyV[0], 1'b0);
        reset_n = 1'b0;
        #2;
        checkIdle(0, "t5_in_reset");
        checkOutput("t5_in_reset_ready", readyV[0], 1'b1);
        stepClk();
        reset_n = 1'b1;
        repeat (5) stepClk();
        checkIdle(0, "t5_released");
        checkOutput("t5_released_ready", readyV[0], 1'b1);
        applyStimulus(0, 8'h81);
        stepClk();
        checkFrame(0, 8'h81, 0, 1, 1);
        stepClk();
        checkIdle(0, "t5_after");

        // 6: pulse on tx_valid while the holding register is full is ignored
        $display("[TB] ignored byte");
        applyStimulus(0, 8'h12);
        stepClk();
        applyStimulus(0, 8'h34);
        checkOutput("t6_hold_full", readyV[0], 1'b0);
        applyStimulus(0, 8'hEE);
        checkOutput("t6_still_full", readyV[0], 1'b0);
        checkFrame(0, 8'h12, 0, 1, 3);
        stepClk();
        checkFrame(0, 8'h34, 0, 1, 1);
        stepClk();
        checkIdle(0, "t6_after");
        checkOutput("t6_after_ready", readyV[0], 1'b1);
        repeat (10) stepClk();
        checkIdle(0, "t6_no_third");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART serial transmitter producing 8-bit frames on TxD: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
Bit timing matches the team's oversampling UART receiver: one bit = DIV_CNT*OVERSAMPLE clocks, so both ends derive identical baud from shared parameters.
A byte-wide valid/ready input with a one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s
OVERSAMPLE, 16, receiver oversample factor, used only to derive timing
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; byte accepted on clk edge when tx_valid && tx_ready
TxD  output  1  serial line, idle high, registered
tx_busy  output  1  high while any frame bit (start through last stop) is being driven
tx_done  output  1  one-cycle pulse on the final clock of the last stop bit

Behaviour:
- Derived constants: DIV_CNT = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) (integer division); BIT_CLKS = DIV_CNT*OVERSAMPLE; counter width $clog2(BIT_CLKS).
- Elaboration error if DIV_CNT < 1, PARITY_MODE > 2, or STOP_BITS is not 1 or 2.
- Reset (asynchronous, reset_n = 0) takes effect immediately and aborts any frame:
  - TxD = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
  - Holding register cleared; FSM returns to IDLE.
- Holding register (hold_full flag):
  - Set on accept; cleared when the FSM loads it into the shift register.
  - tx_ready = !hold_full, so a new byte can be accepted during a frame.
  - tx_valid && !tx_ready: input ignored; the producer must hold data.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD = 1. If hold_full, load shift register, clear hold_full, go to START. Start bit appears on TxD at the next edge, i.e. exactly one clock after the accepting edge when the FSM was idle.
  - START: TxD = 0 for BIT_CLKS clocks, then DATA.
  - DATA: TxD = shift[0] for BIT_CLKS per bit, shifting right; bit counter 0..7. After bit 7, go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: even mode sends XOR of the byte; odd mode sends its inverse. Lasts BIT_CLKS.
  - STOP: TxD = 1 for STOP_BITS*BIT_CLKS. tx_done pulses on the last clock. Then:
    - if hold_full, load and go directly to START (no idle cycle);
    - else go to IDLE.
- Parity is computed from the byte at load time, not from the shifting register.
- Simultaneous accept and load in the same cycle: the load consumes the old entry, hold_full stays 1 with the new byte. No loss, no duplication.
- The bit timer restarts at 0 on every state entry, giving exact BIT_CLKS per bit with no cumulative drift.
- tx_busy = (state != IDLE).

Decomposition:
- Package uart_pkg:
  - tx state enum;
  - PARITY_NONE/EVEN/ODD constants;
  - function computing DIV_CNT from CLK_FREQ/BAUD_RATE/OVERSAMPLE, to be shared with the receiver.
- One sub-module, uart_bit_timer: counter with clear input and a bit_end pulse at BIT_CLKS-1.
- FSM, holding register and shifter stay in uart_transmitter.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, giving BIT_CLKS=160.
1. Send 0xA5, no parity, 1 stop -> TxD falls 1 clock after accept; then 0,1,0,1,0,0,1,0,1,1, each 160 clocks; tx_done pulses at clock 1600 of the frame; tx_busy high for exactly 1600 clocks.
2. Back-to-back 0x00 then 0xFF, tx_valid held high -> tx_ready returns to 1 one clock after first start; second start bit begins on the clock right after first frame's last stop clock; third byte stalls until second frame's start.
3. PARITY_MODE=1 with 0x07 -> parity bit 1, frame length 1760 clocks; PARITY_MODE=2 with 0x07 -> parity bit 0.
4. STOP_BITS=2 with 0x3C -> stop high for 320 clocks; tx_done on clock 1760; a held byte starts immediately after.
5. Assert reset_n=0 mid data bit 3 of 0x55 -> TxD=1, tx_busy=0, tx_ready=1 without waiting for clk; after release, send 0x81 -> correct full frame.
6. tx_valid pulsed while tx_ready=0 (hold full) -> byte not captured; only the held byte is transmitted.
